// File: rtl/fork_join_ctrl.sv
// Fork/join dispatch controller: launches a set of worker lanes, gathers their
// done pulses and answers with a JOIN_ALL / JOIN_ANY / JOIN_NONE response.
module fork_join_ctrl #(
  parameter int N_LANES     = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDX_W       = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_mode,
  input  logic [N_LANES-1:0] req_mask,
  output logic [N_LANES-1:0] lane_start,
  input  logic [N_LANES-1:0] lane_done,
  output logic [N_LANES-1:0] busy_mask,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [N_LANES-1:0] resp_done_mask,
  output logic [IDX_W-1:0]   resp_first_idx,
  output logic               resp_timeout,
  output logic               resp_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [1:0] MODE_ALL  = 2'b00;
  localparam logic [1:0] MODE_ANY  = 2'b01;
  localparam logic [1:0] MODE_NONE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [N_LANES-1:0] mask_q, mask_d;
  logic [N_LANES-1:0] coll_q, coll_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic [N_LANES-1:0] lane_start_q, lane_start_d;
  logic [N_LANES-1:0] busy_q, busy_d;
  logic               resp_valid_q, resp_valid_d;
  logic [N_LANES-1:0] resp_done_q, resp_done_d;
  logic [IDX_W-1:0]   resp_idx_q, resp_idx_d;
  logic               resp_to_q, resp_to_d;
  logic               resp_err_q, resp_err_d;

  logic               accept, reject, resp_hs, term, tmo;
  logic [N_LANES-1:0] new_done;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_LANES-1:0] v);
    lowest_idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign reject   = (req_mode == 2'b11) || ((req_mask & busy_q) != '0);
  assign resp_hs  = resp_valid_q && resp_ready;
  // Only lanes of this request that are still running may count as completions.
  assign new_done = lane_done & mask_q & busy_q;
  assign tmo      = (TIMEOUT_CYC != 0) && (32'(cnt_q) == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    term = 1'b0;
    if (state_q == S_WAIT) begin
      if (mode_q == MODE_ANY) term = |new_done;
      else                    term = ((coll_q | new_done) == mask_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_ALL;
      mask_q       <= '0;
      coll_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      lane_start_q <= '0;
      busy_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_done_q  <= '0;
      resp_idx_q   <= '0;
      resp_to_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      coll_q       <= coll_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      lane_start_q <= lane_start_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_done_q  <= resp_done_d;
      resp_idx_q   <= resp_idx_d;
      resp_to_q    <= resp_to_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = reject ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_d = ((mode_q == MODE_NONE) || (mask_q == '0)) ? S_RESP : S_WAIT;
      S_WAIT:   if (term || tmo) state_d = S_RESP;
      S_RESP:   if (resp_hs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d       = mode_q;
    mask_d       = mask_q;
    coll_d       = coll_q;
    cnt_d        = cnt_q;
    lane_start_d = '0;
    busy_d       = busy_q & ~lane_done;
    resp_valid_d = resp_valid_q;
    resp_done_d  = resp_done_q;
    resp_idx_d   = resp_idx_q;
    resp_to_d    = resp_to_q;
    resp_err_d   = resp_err_q;
    req_ready_d  = (state_d == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_done_d  = '0;
            resp_idx_d   = '0;
            resp_to_d    = 1'b0;
          end else begin
            mode_d       = req_mode;
            mask_d       = req_mask;
            coll_d       = '0;
            lane_start_d = req_mask;
          end
        end
      end
      S_LAUNCH: begin
        // OR-ing after the clear drops done pulses on lanes starting this cycle.
        busy_d = (busy_q & ~lane_done) | mask_q;
        cnt_d  = '0;
        if ((mode_q == MODE_NONE) || (mask_q == '0)) begin
          resp_valid_d = 1'b1;
          resp_done_d  = '0;
          resp_idx_d   = '0;
          resp_to_d    = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      S_WAIT: begin
        coll_d = coll_q | new_done;
        cnt_d  = cnt_q + CNT_W'(1);
        if (term || tmo) begin
          resp_valid_d = 1'b1;
          resp_done_d  = coll_q | new_done;
          resp_idx_d   = (term && (mode_q == MODE_ANY)) ? lowest_idx(new_done) : '0;
          resp_to_d    = !term;
          resp_err_d   = 1'b0;
        end
      end
      S_RESP: begin
        if (resp_hs) begin
          resp_valid_d = 1'b0;
          resp_done_d  = '0;
          resp_idx_d   = '0;
          resp_to_d    = 1'b0;
          resp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready      = req_ready_q;
  assign lane_start     = lane_start_q;
  assign busy_mask      = busy_q;
  assign resp_valid     = resp_valid_q;
  assign resp_done_mask = resp_done_q;
  assign resp_first_idx = resp_idx_q;
  assign resp_timeout   = resp_to_q;
  assign resp_err       = resp_err_q;

endmodule
